// File: rtl/servisia_mem_sched.sv
// servisia_mem_sched: boot sequencer and single-port SRAM arbiter between core and byte loader.
module servisia_mem_sched #(
    parameter int AW           = 21,
    parameter int RESET_CYCLES = 2,
    parameter int CNT_W        = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] core_waddr_i,
    input  logic [7:0]    core_wdata_i,
    input  logic          core_wen_i,
    input  logic [AW-1:0] core_raddr_i,
    input  logic          core_ren_i,
    output logic [7:0]    core_rdata_o,
    output logic          core_rst_no,
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [7:0]    ld_wdata_i,
    output logic          ld_gnt_o,
    output logic          ld_rvalid_o,
    output logic [7:0]    ld_rdata_o,
    input  logic          ld_done_i,
    input  logic          ld_halt_i,
    output logic          boot_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [7:0]    sram_wdata_o,
    output logic          sram_write_o,
    output logic          sram_read_o,
    input  logic [7:0]    sram_rdata_i
);
    typedef enum logic [1:0] {BOOT, TAIL, RUN} state_e;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rvalid_q;
    logic [7:0]       rdata_q;
    logic             core_rst_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_gnt_o     = 1'b0;
        sram_write_o = 1'b0;
        sram_read_o  = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        case (state_q)
            BOOT: begin
                ld_gnt_o = ld_req_i;
                if (ld_done_i && !ld_req_i) begin
                    state_d = TAIL;
                    cnt_d   = '0;
                end
            end
            TAIL: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ld_halt_i ? BOOT : (cnt_q == CNT_W'(RESET_CYCLES - 1)) ? RUN : TAIL;
            end
            RUN: begin
                if (core_wen_i) begin
                    sram_write_o = 1'b1;
                    sram_addr_o  = core_waddr_i;
                    sram_wdata_o = core_wdata_i;
                end else if (core_ren_i) begin
                    sram_read_o = 1'b1;
                    sram_addr_o = core_raddr_i;
                end else begin
                    ld_gnt_o = ld_req_i;
                end
                if (ld_halt_i) state_d = BOOT;
            end
            default: state_d = BOOT;
        endcase
        if (!rst_ni) begin
            ld_gnt_o     = 1'b0;
            sram_write_o = 1'b0;
            sram_read_o  = 1'b0;
        end
        if (ld_gnt_o) begin
            sram_addr_o  = ld_addr_i;
            sram_write_o = ld_we_i;
            sram_read_o  = !ld_we_i;
            sram_wdata_o = ld_we_i ? ld_wdata_i : 8'h00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 8'h00;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= ld_gnt_o && !ld_we_i;
            if (rvalid_q) rdata_q <= sram_rdata_i;
            core_rst_q <= (state_d == RUN);
        end
    end

    // SRAM data arrives in the rvalid cycle, so it is forwarded then and held afterwards
    assign ld_rdata_o   = rvalid_q ? sram_rdata_i : rdata_q;
    assign ld_rvalid_o  = rvalid_q;
    assign core_rdata_o = sram_rdata_i;
    assign core_rst_no  = core_rst_q;
    assign boot_o       = (state_q != RUN);
endmodule

// File: tb/tb_servisia_mem_sched.sv
// tb_servisia_mem_sched: scoreboard bench for the boot sequencer / SRAM arbiter.
module tb_servisia_mem_sched;
    localparam int AW = 21;
    logic          clk = 1'b0;
    logic          rst_ni;
    logic [AW-1:0] core_waddr, core_raddr, ld_addr;
    logic [7:0]    core_wdata, ld_wdata;
    logic          core_wen, core_ren, ld_req, ld_we, ld_done, ld_halt;
    logic [7:0]    core_rdata, ld_rdata, sram_wdata;
    logic          core_rst_n, ld_gnt, ld_rvalid, boot, sram_write, sram_read;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_rdata = 8'h00;
    logic [7:0]    mem [logic [AW-1:0]];
    logic [7:0]    exp_q [$];
    int            n_cmp = 0, n_err = 0, n_rv = 0;
    logic          mon_en = 1'b0;

    servisia_mem_sched #(.AW(AW), .RESET_CYCLES(2), .CNT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_waddr_i(core_waddr), .core_wdata_i(core_wdata), .core_wen_i(core_wen),
        .core_raddr_i(core_raddr), .core_ren_i(core_ren), .core_rdata_o(core_rdata),
        .core_rst_no(core_rst_n),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
        .ld_done_i(ld_done), .ld_halt_i(ld_halt), .boot_o(boot),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_write_o(sram_write),
        .sram_read_o(sram_read), .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    // behavioural SRAM: one-cycle read latency, unwritten bytes read as zero
    always @(posedge clk) begin
        if (sram_read) sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 8'h00;
        if (sram_write) mem[sram_addr] = sram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("strobe_excl", {31'd0, sram_write & sram_read}, 0);
        if (ld_rvalid) begin
            n_rv++;
            if (exp_q.size() == 0) chk("rvalid_unexpected", 1, 0);
            else chk("ld_rdata", {24'd0, ld_rdata}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_wen = 0; core_ren = 0; ld_req = 0; ld_we = 0; ld_done = 0; ld_halt = 0;
        core_waddr = '0; core_raddr = '0; core_wdata = '0; ld_addr = '0; ld_wdata = '0;
    endtask

    task automatic ld(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = d;
    endtask

    initial begin
        idle();
        rst_ni = 0; core_wen = 1; core_ren = 1; ld_req = 1; ld_we = 0; ld_addr = 21'h10;
        repeat (3) tick();
        chk("rst_write", {31'd0, sram_write}, 0);
        chk("rst_read", {31'd0, sram_read}, 0);
        chk("rst_gnt", {31'd0, ld_gnt}, 0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 0);
        chk("rst_boot", {31'd0, boot}, 1);
        chk("rst_rvalid", {31'd0, ld_rvalid}, 0);
        chk("rst_rdata", {24'd0, ld_rdata}, 0);
        idle(); rst_ni = 1; mon_en = 1;
        tick();
        ld(1, 21'h10, 8'hA5); core_wen = 1; core_waddr = 21'h20; core_wdata = 8'h11;
        #1;
        chk("boot_wr_gnt", {31'd0, ld_gnt}, 1);
        chk("boot_wr_strobe", {31'd0, sram_write}, 1);
        chk("boot_wr_addr", {11'd0, sram_addr}, 32'h10);
        chk("boot_wr_data", {24'd0, sram_wdata}, 32'hA5);
        tick();
        ld(0, 21'h10, 8'h00); core_wen = 1;
        #1;
        chk("boot_rd_gnt", {31'd0, ld_gnt}, 1);
        chk("boot_rd_strobe", {31'd0, sram_read}, 1);
        chk("boot_rd_nowrite", {31'd0, sram_write}, 0);
        exp_q.push_back(8'hA5);
        tick();
        chk("boot_rvalid", {31'd0, ld_rvalid}, 1);
        idle(); ld(1, 21'h11, 8'h5A); ld_done = 1;
        #1;
        chk("done_req_gnt", {31'd0, ld_gnt}, 1);
        tick();
        ld_done = 0; ld(0, 21'h11, 8'h00);
        #1;
        chk("still_boot_gnt", {31'd0, ld_gnt}, 1);
        chk("still_boot", {31'd0, boot}, 1);
        exp_q.push_back(8'h5A);
        tick();
        idle(); ld_done = 1;
        tick();
        idle(); ld(0, 21'h10, 8'h00);
        #1;
        chk("tail1_boot", {31'd0, boot}, 1);
        chk("tail1_gnt", {31'd0, ld_gnt}, 0);
        chk("tail1_read", {31'd0, sram_read}, 0);
        chk("tail1_core_rst_n", {31'd0, core_rst_n}, 0);
        tick();
        chk("tail2_boot", {31'd0, boot}, 1);
        chk("tail2_gnt", {31'd0, ld_gnt}, 0);
        chk("tail2_core_rst_n", {31'd0, core_rst_n}, 0);
        tick();
        idle();
        #1;
        chk("run_boot", {31'd0, boot}, 0);
        chk("run_core_rst_n", {31'd0, core_rst_n}, 1);
        core_wen = 1; core_ren = 1; core_waddr = 21'h30; core_wdata = 8'h77; core_raddr = 21'h40;
        ld(0, 21'h10, 8'h00);
        #1;
        chk("prio_write", {31'd0, sram_write}, 1);
        chk("prio_noread", {31'd0, sram_read}, 0);
        chk("prio_gnt", {31'd0, ld_gnt}, 0);
        chk("prio_addr", {11'd0, sram_addr}, 32'h30);
        chk("prio_wdata", {24'd0, sram_wdata}, 32'h77);
        tick();
        core_wen = 0; core_ren = 0;
        #1;
        chk("idle_gnt", {31'd0, ld_gnt}, 1);
        chk("idle_read", {31'd0, sram_read}, 1);
        chk("idle_addr", {11'd0, sram_addr}, 32'h10);
        exp_q.push_back(8'hA5);
        tick();
        idle(); ld(1, 21'h1FFFFF, 8'hC3);
        tick();
        idle(); core_ren = 1; core_raddr = 21'h30;
        tick();
        chk("core_rdata_30", {24'd0, core_rdata}, 32'h77);
        core_raddr = 21'h1FFFFF;
        #1;
        chk("max_addr", {11'd0, sram_addr}, 32'h1FFFFF);
        chk("max_read", {31'd0, sram_read}, 1);
        tick();
        idle();
        #1;
        chk("core_rdata_max", {24'd0, core_rdata}, 32'hC3);
        ld(0, 21'h20, 8'h00); ld_halt = 1;
        #1;
        chk("halt_gnt", {31'd0, ld_gnt}, 1);
        exp_q.push_back(8'h00);
        tick();
        idle();
        #1;
        chk("halt_rvalid", {31'd0, ld_rvalid}, 1);
        chk("halt_core_rst_n", {31'd0, core_rst_n}, 0);
        chk("halt_boot", {31'd0, boot}, 1);
        ld(1, 21'h10, 8'h3C);
        tick();
        idle(); ld_done = 1;
        tick();
        idle();
        tick();
        tick();
        chk("reload_core_rst_n", {31'd0, core_rst_n}, 1);
        ld(0, 21'h10, 8'h00);
        #1;
        chk("reload_gnt", {31'd0, ld_gnt}, 1);
        exp_q.push_back(8'h3C);
        tick();
        idle();
        tick();
        chk("queue_empty", exp_q.size(), 0);
        chk("rvalid_count", n_rv, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/servisia_mem_sched.md
Name: servisia_mem_sched

Overview:
Sequencer and arbiter for the single 8-bit SRAM port of servisia. Owns boot sequencing:
- holds the core in reset while a loader fills memory;
- releases the core after a fixed reset tail;
- in RUN, shares the SRAM between the core (strict priority, no stall possible) and the loader (idle-slot access).

Sits between subservient_core's SRAM interface, a byte loader (UART/debug) and servisia_mem.

Parameters:
AW, 21, SRAM byte-address width
RESET_CYCLES, 2, cycles core reset stays asserted after loader finishes (>=1)
CNT_W, 4, width of reset-tail counter (2^CNT_W > RESET_CYCLES)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
core_waddr_i  in  AW  core write address
core_wdata_i  in  8  core write data
core_wen_i  in  1  core write strobe
core_raddr_i  in  AW  core read address
core_ren_i  in  1  core read strobe
core_rdata_o  out  8  core read data (sram_rdata_i passthrough)
core_rst_no  out  1  active-low reset to core
ld_req_i  in  1  loader access request
ld_we_i  in  1  loader write(1)/read(0)
ld_addr_i  in  AW  loader address
ld_wdata_i  in  8  loader write data
ld_gnt_o  out  1  loader access accepted this cycle
ld_rvalid_o  out  1  loader read data valid
ld_rdata_o  out  8  loader read data
ld_done_i  in  1  loader finished boot image
ld_halt_i  in  1  request return to BOOT (re-load)
boot_o  out  1  1 while in BOOT or TAIL
sram_addr_o  out  AW  SRAM address
sram_wdata_o  out  8  SRAM write data
sram_write_o  out  1  SRAM write strobe
sram_read_o  out  1  SRAM read strobe
sram_rdata_i  in  8  SRAM read data, valid cycle after sram_read_o

Behaviour:
- States: BOOT, TAIL, RUN. All state is synchronous to clk_i.
- Reset (rst_ni=0 at edge): state=BOOT, tail counter=0, ld_rvalid_o=0, ld_rdata_o=0, core_rst_no=0.
- During reset, combinational SRAM strobes are forced 0 and ld_gnt_o=0.
- core_rst_no = (state==RUN), registered: deasserts on the first cycle in RUN. boot_o = (state!=RUN).
- BOOT:
  - Loader owns the SRAM; core inputs are ignored.
  - ld_gnt_o = ld_req_i, same cycle (combinational).
  - Granted write: sram_write_o=1, sram_addr_o=ld_addr_i, sram_wdata_o=ld_wdata_i.
  - Granted read: sram_read_o=1, sram_addr_o=ld_addr_i.
  - ld_done_i=1 with ld_req_i=0 -> TAIL, counter cleared.
  - ld_done_i together with ld_req_i: the access is served, state stays BOOT, and done is ignored; the loader must re-assert done.
- TAIL:
  - No SRAM access; ld_gnt_o=0; counter increments every cycle.
  - When counter==RESET_CYCLES-1 -> RUN. Core reset is therefore held RESET_CYCLES cycles after leaving BOOT.
  - ld_halt_i -> BOOT.
- RUN:
  - Core has strict priority every cycle.
  - core_wen_i=1: write at core_waddr_i/core_wdata_i, even if core_ren_i=1 simultaneously (write wins).
  - Else core_ren_i=1: read at core_raddr_i.
  - Else (core idle): ld_gnt_o=ld_req_i, and the loader access is performed as in BOOT.
  - Loader may wait indefinitely; no starvation guarantee.
  - ld_halt_i=1 -> BOOT next cycle. Any access in the halt cycle still completes; core_rst_no drops the next cycle.
- Read return:
  - ld_rvalid_o registers (granted loader read); it is a 1-cycle pulse one cycle after grant.
  - ld_rdata_o is captured from sram_rdata_i in the cycle ld_rvalid_o is high; ld_rvalid_o rises the cycle after the grant.
  - core_rdata_o is always sram_rdata_i; the core samples it the cycle after its ren.
- Idle SRAM outputs: strobes 0, addr/wdata don't-care (drive 0).
- A loader read granted in the last RUN cycle before halt still returns ld_rvalid_o.
- Reset mid-access: the access is dropped and ld_rvalid_o is cleared.
- Never assert sram_write_o and sram_read_o together.

Test Plan:
- Reset, then hold 3 cycles -> state BOOT, core_rst_no=0, all strobes 0, ld_rvalid_o=0.
- BOOT: loader writes 0xA5 @0x00010, then reads @0x00010 -> ld_gnt_o same cycle; next cycle ld_rvalid_o=1, ld_rdata_o=0xA5; core_wen_i pulses ignored.
- ld_done_i with ld_req_i=0 and RESET_CYCLES=2 -> boot_o stays 1 for 2 cycles; core_rst_no rises exactly 3 cycles after done; ld_req_i in TAIL gets no grant.
- RUN: core_wen_i=1 and core_ren_i=1 plus ld_req_i in the same cycle -> core write performed, no read, ld_gnt_o=0; loader is granted in the first cycle the core is idle.
- RUN: core read @0x1FFFFF (max address) -> sram_addr_o=0x1FFFFF, sram_read_o=1; core_rdata_o follows sram_rdata_i the next cycle.
- ld_halt_i in RUN during a granted loader read -> ld_rvalid_o pulses next cycle, core_rst_no=0 next cycle, state BOOT; full reload and done return to RUN.
